// File: rtl/pll_mon_pkg.sv
// Shared state encoding, default window/range constants and Gray decode for the PLL clock monitor.
// Pure declarations: no latency, no flow control.
package pll_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MONITOR = 2'd2,
      ST_FAULT   = 2'd3
   } mon_state_t;

   localparam int DEF_CNT_W      = 16;
   localparam int DEF_WIN_CYC    = 1024;
   localparam int DEF_EXP_MIN    = 5018;
   localparam int DEF_EXP_MAX    = 5222;
   localparam int DEF_SETTLE_WIN = 4;
   localparam int DEF_FAULT_THR  = 2;
   localparam int DEF_FAULT_HOLD = 8;

   // Widest counter the decode helper supports; narrower counters are zero-extended.
   localparam int GRAY_MAX_W = 32;

   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/clk_edge_cnt_cdc.sv
// Gray edge counter on mon_clk, carried into aux_clk through a 2-flop sync and decoded to binary.
// Latency 2 aux_clk cycles from Gray update to cnt_bin; free-running, no backpressure.
module clk_edge_cnt_cdc
   import pll_mon_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             aux_clk,
   input  logic             core_rst_n,
   input  logic             mon_clk,
   output logic [CNT_W-1:0] cnt_bin
);

   logic [1:0]       mon_rst_sync;
   logic             mon_rst_n;
   logic [CNT_W-1:0] bin_m;
   logic [CNT_W-1:0] bin_m_nxt;
   logic [CNT_W-1:0] gray_m;
   logic [CNT_W-1:0] gray_meta;
   logic [CNT_W-1:0] gray_s;

   // Assert asynchronously, release on mon_clk so the counter never starts mid-edge.
   always_ff @(posedge mon_clk or negedge core_rst_n) begin
      if (!core_rst_n)
         mon_rst_sync <= 2'b00;
      else
         mon_rst_sync <= {mon_rst_sync[0], 1'b1};
   end

   assign mon_rst_n = mon_rst_sync[1];
   assign bin_m_nxt = bin_m + CNT_W'(1);

   always_ff @(posedge mon_clk or negedge mon_rst_n) begin
      if (!mon_rst_n) begin
         bin_m  <= '0;
         gray_m <= '0;
      end else begin
         bin_m  <= bin_m_nxt;
         gray_m <= bin_m_nxt ^ (bin_m_nxt >> 1);
      end
   end

   // Only one Gray bit moves per mon_clk edge, so a sampled word is always a neighbouring count.
   always_ff @(posedge aux_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         gray_meta <= '0;
         gray_s    <= '0;
      end else begin
         gray_meta <= gray_m;
         gray_s    <= gray_meta;
      end
   end

   assign cnt_bin = CNT_W'(gray2bin(GRAY_MAX_W'(gray_s)));

endmodule

// File: rtl/pll_clk_mon.sv
// PLL output clock supervisor: windowed edge count, range check, settle/monitor/fault FSM, relock request.
// freq_valid 1 cycle after window end, FSM acts 1 cycle later; status only, no backpressure.
module pll_clk_mon
   import pll_mon_pkg::*;
#(
   parameter int CNT_W      = DEF_CNT_W,
   parameter int WIN_CYC    = DEF_WIN_CYC,
   parameter int EXP_MIN    = DEF_EXP_MIN,
   parameter int EXP_MAX    = DEF_EXP_MAX,
   parameter int SETTLE_WIN = DEF_SETTLE_WIN,
   parameter int FAULT_THR  = DEF_FAULT_THR,
   parameter int FAULT_HOLD = DEF_FAULT_HOLD
) (
   input  logic             aux_clk,
   input  logic             core_rst_n,
   input  logic             mon_clk,
   input  logic             lock_in,
   output logic [CNT_W-1:0] freq_cnt,
   output logic             freq_valid,
   output logic             clk_ok,
   output logic             relock_req,
   output logic [7:0]       fault_cnt
);

   localparam int WIN_W  = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
   localparam int SET_W  = (SETTLE_WIN > 1) ? $clog2(SETTLE_WIN) : 1;
   localparam int BAD_W  = (FAULT_THR > 1) ? $clog2(FAULT_THR) : 1;
   localparam int HOLD_W = $clog2(FAULT_HOLD + 1);

   localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WIN_CYC - 1);
   localparam logic [SET_W-1:0]  SET_LAST    = SET_W'(SETTLE_WIN - 1);
   localparam logic [BAD_W-1:0]  BAD_LAST    = BAD_W'(FAULT_THR - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(FAULT_HOLD);
   localparam logic [CNT_W-1:0]  EXP_MIN_CNT = CNT_W'(EXP_MIN);
   localparam logic [CNT_W-1:0]  EXP_MAX_CNT = CNT_W'(EXP_MAX);

   logic [CNT_W-1:0]  cnt_bin;
   logic [CNT_W-1:0]  prev_bin;
   logic              lock_meta;
   logic              lock_s;
   logic [WIN_W-1:0]  win_cnt;
   logic              win_tc;
   logic              primed;
   logic              win_bad;
   mon_state_t        state;
   logic [SET_W-1:0]  settle_cnt;
   logic [BAD_W-1:0]  bad_cnt;
   logic [HOLD_W-1:0] hold_cnt;

   clk_edge_cnt_cdc #(
      .CNT_W (CNT_W)
   ) u_edge_cnt (
      .aux_clk    (aux_clk),
      .core_rst_n (core_rst_n),
      .mon_clk    (mon_clk),
      .cnt_bin    (cnt_bin)
   );

   always_ff @(posedge aux_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= lock_in;
         lock_s    <= lock_meta;
      end
   end

   assign win_tc = (state != ST_IDLE) && (win_cnt == WIN_LAST);

   // The first window after IDLE has no valid start sample, so it only primes prev_bin.
   always_ff @(posedge aux_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         win_cnt    <= '0;
         prev_bin   <= '0;
         primed     <= 1'b0;
         freq_cnt   <= '0;
         freq_valid <= 1'b0;
      end else if (state == ST_IDLE) begin
         win_cnt    <= '0;
         primed     <= 1'b0;
         freq_valid <= 1'b0;
      end else begin
         freq_valid <= win_tc && primed;
         if (win_tc) begin
            win_cnt  <= '0;
            prev_bin <= cnt_bin;
            primed   <= 1'b1;
            if (primed)
               freq_cnt <= cnt_bin - prev_bin;
         end else begin
            win_cnt <= win_cnt + WIN_W'(1);
         end
      end
   end

   assign win_bad = (freq_cnt < EXP_MIN_CNT) || (freq_cnt > EXP_MAX_CNT);

   // Lock loss outranks a same-cycle window result; the PLL sequencer owns that recovery.
   always_ff @(posedge aux_clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         state      <= ST_IDLE;
         settle_cnt <= '0;
         bad_cnt    <= '0;
         hold_cnt   <= '0;
         clk_ok     <= 1'b0;
         relock_req <= 1'b0;
         fault_cnt  <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               settle_cnt <= '0;
               bad_cnt    <= '0;
               hold_cnt   <= '0;
               clk_ok     <= 1'b0;
               relock_req <= 1'b0;
               if (lock_s)
                  state <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (!lock_s) begin
                  state <= ST_IDLE;
               end else if (freq_valid) begin
                  if (settle_cnt == SET_LAST) begin
                     state  <= ST_MONITOR;
                     clk_ok <= 1'b1;
                  end else begin
                     settle_cnt <= settle_cnt + SET_W'(1);
                  end
               end
            end
            ST_MONITOR: begin
               if (!lock_s) begin
                  state  <= ST_IDLE;
                  clk_ok <= 1'b0;
               end else if (freq_valid) begin
                  if (!win_bad) begin
                     bad_cnt <= '0;
                  end else if (bad_cnt == BAD_LAST) begin
                     state    <= ST_FAULT;
                     clk_ok   <= 1'b0;
                     bad_cnt  <= '0;
                     hold_cnt <= '0;
                     if (fault_cnt != 8'hff)
                        fault_cnt <= fault_cnt + 8'd1;
                  end else begin
                     bad_cnt <= bad_cnt + BAD_W'(1);
                  end
               end
            end
            ST_FAULT: begin
               if (hold_cnt == HOLD_LAST) begin
                  relock_req <= 1'b0;
                  state      <= ST_IDLE;
               end else begin
                  relock_req <= 1'b1;
                  hold_cnt   <= hold_cnt + HOLD_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pll_clk_mon.sv
// Bench for pll_clk_mon: 25 MHz aux, variable/stoppable mon clock, expectations from a period-based model.
`timescale 1ns/1ps
module tb_pll_clk_mon;

   localparam int  CNT_W      = 16;
   localparam int  WIN_CYC    = 1024;
   localparam int  EXP_MIN    = 5018;
   localparam int  EXP_MAX    = 5222;
   localparam int  SETTLE_WIN = 4;
   localparam int  FAULT_THR  = 2;
   localparam int  FAULT_HOLD = 8;
   localparam real AUX_PER    = 40.0;
   localparam int  WIN_BUDGET = WIN_CYC + 16;

   logic             aux_clk = 1'b0;
   logic             core_rst_n = 1'b0;
   logic             mon_clk = 1'b0;
   logic             lock_in = 1'b0;
   logic [CNT_W-1:0] freq_cnt;
   logic             freq_valid;
   logic             clk_ok;
   logic             relock_req;
   logic [7:0]       fault_cnt;

   int      tests = 0;
   int      fails = 0;
   int      cyc = 0;
   int      rel_cyc = 0;
   realtime mon_half = 4.0;
   bit      mon_run = 1'b1;
   longint  mon_edges = 0;
   int      relock_pulses = 0;
   int      relock_len = 0;
   int      relock_run = 0;

   pll_clk_mon #(
      .CNT_W (CNT_W), .WIN_CYC (WIN_CYC), .EXP_MIN (EXP_MIN), .EXP_MAX (EXP_MAX),
      .SETTLE_WIN (SETTLE_WIN), .FAULT_THR (FAULT_THR), .FAULT_HOLD (FAULT_HOLD)
   ) dut (
      .aux_clk    (aux_clk),
      .core_rst_n (core_rst_n),
      .mon_clk    (mon_clk),
      .lock_in    (lock_in),
      .freq_cnt   (freq_cnt),
      .freq_valid (freq_valid),
      .clk_ok     (clk_ok),
      .relock_req (relock_req),
      .fault_cnt  (fault_cnt)
   );

   always #(AUX_PER / 2.0) aux_clk = ~aux_clk;

   initial begin
      #1.3;
      forever begin
         if (mon_run) begin
            #(mon_half) mon_clk = ~mon_clk;
         end else begin
            #(1.0);
         end
      end
   end

   always @(posedge aux_clk) cyc++;
   always @(posedge mon_clk) if (core_rst_n) mon_edges++;

   always @(negedge aux_clk) begin
      if (!core_rst_n) begin
         relock_run = 0;
      end else if (relock_req === 1'b1) begin
         relock_run++;
      end else if (relock_run > 0) begin
         relock_pulses++;
         relock_len = relock_run;
         relock_run = 0;
      end
   end

   initial begin
      #(5ms);
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   // Reference: edges in one window of WIN_CYC aux periods at a given mon half-period.
   function automatic real exp_cnt(input real half);
      return real'(WIN_CYC) * AUX_PER / (2.0 * half);
   endfunction

   function automatic bit model_bad(input real half);
      real e;
      e = exp_cnt(half);
      return (e < real'(EXP_MIN)) || (e > real'(EXP_MAX));
   endfunction

   task automatic wait_valid(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge aux_clk);
         if (freq_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_relock(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge aux_clk);
         if (relock_req === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic reach_monitor();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 6 * WIN_CYC + 64; i++) begin
         @(negedge aux_clk);
         if (clk_ok === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL reach_monitor: clk_ok never rose, got %b required 1", clk_ok);
      end
      wait_valid(WIN_BUDGET, ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL monitor_align: no freq_valid within %0d cycles", WIN_BUDGET);
      end
   endtask

   task automatic test_reset();
      core_rst_n = 1'b0;
      lock_in    = 1'b1;
      mon_half   = 4.0;
      repeat (3) @(negedge aux_clk);
      tests += 5;
      if (freq_cnt !== '0)   begin fails++; $display("FAIL reset_freq_cnt: got %0d required 0", freq_cnt); end
      if (freq_valid !== 0)  begin fails++; $display("FAIL reset_freq_valid: got %b required 0", freq_valid); end
      if (clk_ok !== 0)      begin fails++; $display("FAIL reset_clk_ok: got %b required 0", clk_ok); end
      if (relock_req !== 0)  begin fails++; $display("FAIL reset_relock_req: got %b required 0", relock_req); end
      if (fault_cnt !== 0)   begin fails++; $display("FAIL reset_fault_cnt: got %0d required 0", fault_cnt); end
      core_rst_n = 1'b1;
      rel_cyc = cyc;
   endtask

   task automatic test_nominal();
      bit  ok;
      int  lat;
      real e;
      e = exp_cnt(mon_half);
      for (int w = 1; w <= SETTLE_WIN + 2; w++) begin
         wait_valid((w == 1) ? 3 * WIN_CYC : WIN_BUDGET, ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL nominal_valid_timeout: window %0d got none required a strobe", w);
         end
         if (w == 1) begin
            lat = cyc - rel_cyc;
            tests++;
            if (lat < 2 * WIN_CYC || lat > 2 * WIN_CYC + 8) begin
               fails++;
               $display("FAIL first_valid_latency: got %0d cycles required %0d..%0d", lat, 2 * WIN_CYC, 2 * WIN_CYC + 8);
            end
         end
         tests++;
         if (real'(freq_cnt) - e > 1.0 || e - real'(freq_cnt) > 1.0) begin
            fails++;
            $display("FAIL nominal_freq_cnt: window %0d got %0d required %0.1f +-1", w, freq_cnt, e);
         end
         tests++;
         if (clk_ok !== ((w > SETTLE_WIN) ? 1'b1 : 1'b0)) begin
            fails++;
            $display("FAIL nominal_clk_ok: window %0d got %b required %b", w, clk_ok, (w > SETTLE_WIN));
         end
         if (w == SETTLE_WIN) begin
            @(negedge aux_clk);
            tests++;
            if (clk_ok !== 1'b1) begin
               fails++;
               $display("FAIL settle_to_monitor: got clk_ok=%b required 1", clk_ok);
            end
         end
      end
      tests += 2;
      if (relock_pulses !== 0) begin fails++; $display("FAIL nominal_no_relock: got %0d pulses required 0", relock_pulses); end
      if (fault_cnt !== 0)     begin fails++; $display("FAIL nominal_fault_cnt: got %0d required 0", fault_cnt); end
   endtask

   task automatic test_wrap();
      bit     ok;
      bit     crossed;
      int     after;
      longint e0;
      longint e1;
      real    e;
      crossed = 1'b0;
      after   = 0;
      e0      = mon_edges;
      e       = exp_cnt(mon_half);
      for (int w = 0; w < 16 && after < 2; w++) begin
         wait_valid(WIN_BUDGET, ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL wrap_valid_timeout: window %0d got none required a strobe", w);
         end
         e1 = mon_edges;
         tests++;
         if (real'(freq_cnt) - e > 1.0 || e - real'(freq_cnt) > 1.0) begin
            fails++;
            $display("FAIL wrap_freq_cnt: window %0d got %0d required %0.1f +-1", w, freq_cnt, e);
         end
         if ((e1 >> CNT_W) != (e0 >> CNT_W)) crossed = 1'b1;
         if (crossed) after++;
         e0 = e1;
      end
      tests++;
      if (!crossed) begin
         fails++;
         $display("FAIL wrap_reached: got %0d edges required a 2^%0d crossing", mon_edges, CNT_W);
      end
   endtask

   task automatic test_single_bad();
      bit  ok;
      int  f0, p0, run, pred, pairs;
      real h, e;
      f0    = fault_cnt;
      p0    = relock_pulses;
      run   = 0;
      pred  = 0;
      pairs = 2 + $urandom_range(0, 1);
      for (int k = 0; k < 2 * pairs; k++) begin
         if (k % 2 == 0) h = real'($urandom_range(4700, 5300)) / 1000.0;
         else            h = real'($urandom_range(3950, 4050)) / 1000.0;
         mon_half = h;
         e = exp_cnt(h);
         wait_valid(WIN_BUDGET, ok);
         tests++;
         if (!ok) begin
            fails++;
            $display("FAIL single_bad_timeout: window %0d got none required a strobe", k);
         end
         tests++;
         if (real'(freq_cnt) - e > 8.0 || e - real'(freq_cnt) > 8.0) begin
            fails++;
            $display("FAIL single_bad_freq_cnt: window %0d got %0d required %0.1f +-8", k, freq_cnt, e);
         end
         tests++;
         if (clk_ok !== 1'b1) begin
            fails++;
            $display("FAIL single_bad_clk_ok: window %0d got %b required 1", k, clk_ok);
         end
         run = model_bad(h) ? run + 1 : 0;
         if (run == FAULT_THR) begin
            pred++;
            run = 0;
         end
      end
      mon_half = 4.0;
      repeat (FAULT_HOLD + 4) @(negedge aux_clk);
      tests += 3;
      if (fault_cnt !== 8'(f0 + pred))       begin fails++; $display("FAIL single_bad_fault_cnt: got %0d required %0d", fault_cnt, f0 + pred); end
      if (relock_pulses !== p0 + pred)       begin fails++; $display("FAIL single_bad_relock: got %0d pulses required %0d", relock_pulses, p0 + pred); end
      if (clk_ok !== ((pred == 0) ? 1'b1 : 1'b0)) begin fails++; $display("FAIL single_bad_final_clk_ok: got %b required %b", clk_ok, pred == 0); end
   endtask

   task automatic check_fault(input string tag, input int f0, input int p0, input int c0);
      bit ok;
      wait_relock(8, ok);
      tests += 2;
      if (!ok) begin
         fails++;
         $display("FAIL %s_relock_rise: got none required relock_req", tag);
      end
      if (cyc - c0 != 2) begin
         fails++;
         $display("FAIL %s_relock_latency: got %0d cycles required 2", tag, cyc - c0);
      end
      repeat (FAULT_HOLD + 2) @(negedge aux_clk);
      tests += 4;
      if (relock_pulses !== p0 + 1)   begin fails++; $display("FAIL %s_relock_count: got %0d required %0d", tag, relock_pulses, p0 + 1); end
      if (relock_len !== FAULT_HOLD)  begin fails++; $display("FAIL %s_relock_width: got %0d required %0d", tag, relock_len, FAULT_HOLD); end
      if (fault_cnt !== 8'(f0 + 1))   begin fails++; $display("FAIL %s_fault_cnt: got %0d required %0d", tag, fault_cnt, f0 + 1); end
      if (clk_ok !== 1'b0)            begin fails++; $display("FAIL %s_clk_ok: got %b required 0", tag, clk_ok); end
   endtask

   task automatic test_freq_fault();
      bit ok;
      int f0, p0;
      f0 = fault_cnt;
      p0 = relock_pulses;
      mon_half = 5.0;
      wait_valid(WIN_BUDGET, ok);
      tests += 2;
      if (!ok || freq_cnt >= EXP_MIN) begin fails++; $display("FAIL freq_fault_bad1: got %0d required < %0d", freq_cnt, EXP_MIN); end
      if (clk_ok !== 1'b1)            begin fails++; $display("FAIL freq_fault_clk_ok_hold: got %b required 1", clk_ok); end
      wait_valid(WIN_BUDGET, ok);
      tests++;
      if (!ok || real'(freq_cnt) - exp_cnt(5.0) > 1.0 || exp_cnt(5.0) - real'(freq_cnt) > 1.0) begin
         fails++;
         $display("FAIL freq_fault_bad2: got %0d required %0.1f +-1", freq_cnt, exp_cnt(5.0));
      end
      check_fault("freq_fault", f0, p0, cyc);
      mon_half = 4.0;
   endtask

   task automatic test_lock_drop_bad();
      bit ok;
      int f0, p0, c1, cd;
      reach_monitor();
      f0 = fault_cnt;
      p0 = relock_pulses;
      mon_half = 5.0;
      wait_valid(WIN_BUDGET, ok);
      c1 = cyc;
      tests++;
      if (!ok || freq_cnt >= EXP_MIN) begin fails++; $display("FAIL lock_drop_bad1: got %0d required < %0d", freq_cnt, EXP_MIN); end
      repeat (WIN_CYC - 2) @(negedge aux_clk);
      tests++;
      if (clk_ok !== 1'b1) begin fails++; $display("FAIL lock_drop_pre_clk_ok: got %b required 1", clk_ok); end
      lock_in = 1'b0;
      cd = cyc;
      repeat (2) @(negedge aux_clk);
      tests++;
      if (freq_valid !== 1'b1) begin fails++; $display("FAIL lock_drop_coincide: got freq_valid=%b at cycle %0d required 1", freq_valid, cyc - c1); end
      @(negedge aux_clk);
      tests++;
      if (clk_ok !== 1'b0) begin fails++; $display("FAIL lock_drop_clk_ok: got %b %0d cycles after drop required 0", clk_ok, cyc - cd); end
      repeat (FAULT_HOLD + 4) @(negedge aux_clk);
      tests += 3;
      if (relock_pulses !== p0)    begin fails++; $display("FAIL lock_drop_no_relock: got %0d pulses required %0d", relock_pulses, p0); end
      if (relock_req !== 1'b0)     begin fails++; $display("FAIL lock_drop_relock_req: got %b required 0", relock_req); end
      if (fault_cnt !== 8'(f0))    begin fails++; $display("FAIL lock_drop_fault_cnt: got %0d required %0d", fault_cnt, f0); end
      lock_in  = 1'b1;
      mon_half = 4.0;
   endtask

   task automatic test_stop_clk();
      bit ok;
      int f0, p0;
      reach_monitor();
      f0 = fault_cnt;
      p0 = relock_pulses;
      mon_run = 1'b0;
      wait_valid(WIN_BUDGET, ok);
      tests++;
      if (!ok || freq_cnt >= EXP_MIN) begin fails++; $display("FAIL stop_bad1: got %0d required < %0d", freq_cnt, EXP_MIN); end
      wait_valid(WIN_BUDGET, ok);
      tests++;
      if (!ok || freq_cnt !== '0) begin fails++; $display("FAIL stop_freq_cnt: got %0d required 0", freq_cnt); end
      check_fault("stop", f0, p0, cyc);
      mon_run = 1'b1;
   endtask

   task automatic test_reset_in_fault();
      bit ok;
      reach_monitor();
      mon_half = 5.0;
      wait_valid(WIN_BUDGET, ok);
      wait_valid(WIN_BUDGET, ok);
      wait_relock(8, ok);
      repeat (3) @(negedge aux_clk);
      tests++;
      if (relock_req !== 1'b1) begin fails++; $display("FAIL rst_fault_pre: got relock_req=%b required 1", relock_req); end
      #7 core_rst_n = 1'b0;
      #1;
      tests += 5;
      if (relock_req !== 1'b0) begin fails++; $display("FAIL rst_fault_relock: got %b required 0", relock_req); end
      if (clk_ok !== 1'b0)     begin fails++; $display("FAIL rst_fault_clk_ok: got %b required 0", clk_ok); end
      if (freq_cnt !== '0)     begin fails++; $display("FAIL rst_fault_freq_cnt: got %0d required 0", freq_cnt); end
      if (freq_valid !== 1'b0) begin fails++; $display("FAIL rst_fault_freq_valid: got %b required 0", freq_valid); end
      if (fault_cnt !== 8'd0)  begin fails++; $display("FAIL rst_fault_fault_cnt: got %0d required 0", fault_cnt); end
      @(negedge aux_clk);
      core_rst_n = 1'b1;
      mon_half   = 4.0;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_wrap();
      test_single_bad();
      test_freq_fault();
      test_lock_drop_bad();
      test_stop_clk();
      test_reset_in_fault();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
